// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues imem requests, skids one
// instruction on stall, squashes on redirect. Optional FETCH_PERF_EN adds perf counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_npc,
  output logic        squash,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    BUFFERED = 2'd2,
    HALTED   = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic        accept_redirect;
  logic        misaligned;
  logic        capture;

  assign misaligned = |redirect_target[1:0];
  // A fetch completes only when no halt/redirect overrides the cycle.
  assign capture    = (state == FETCH) && imem_ready && !halt && !redirect;
  assign imem_req   = (state == FETCH);
  assign imem_addr  = pc;
  assign squash     = accept_redirect;
  assign dbg_state  = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next      = state;
    accept_redirect = 1'b0;
    if (state != HALTED) begin
      if (halt) begin
        state_next = HALTED;
      end else if (redirect) begin
        accept_redirect = 1'b1;
        state_next      = misaligned ? HALTED : FETCH;
      end else begin
        case (state)
          IDLE:     state_next = FETCH;
          FETCH:    if (imem_ready && stall) state_next = BUFFERED;
          BUFFERED: if (!stall) state_next = FETCH;
          default:  state_next = state;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc        <= RESET_PC;
      if_valid  <= 1'b0;
      if_instr  <= '0;
      if_pc     <= '0;
      if_npc    <= '0;
      buf_instr <= '0;
      buf_pc    <= '0;
      halted    <= 1'b0;
      fault     <= 1'b0;
    end else if (state != HALTED) begin
      if (halt) begin
        if_valid <= 1'b0;
        halted   <= 1'b1;
      end else if (redirect) begin
        if_valid  <= 1'b0;
        buf_instr <= '0;
        buf_pc    <= '0;
        if (misaligned) begin
          fault  <= 1'b1;
          halted <= 1'b1;
        end else begin
          pc <= redirect_target;
        end
      end else if (capture) begin
        pc <= pc + 32'd4;
        if (stall) begin
          buf_instr <= imem_rdata;
          buf_pc    <= pc;
        end else begin
          if_valid <= 1'b1;
          if_instr <= imem_rdata;
          if_pc    <= pc;
          if_npc   <= pc + 32'd4;
        end
      end else if (state == FETCH && !stall) begin
        if_valid <= 1'b0;
      end else if (state == BUFFERED && !stall) begin
        if_valid <= 1'b1;
        if_instr <= buf_instr;
        if_pc    <= buf_pc;
        if_npc   <= buf_pc + 32'd4;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_fetches      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (capture) perf_fetches <= perf_fetches + 32'd1;
      if (stall && state != HALTED) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected fetch addresses are queued as
// fetches are driven and popped when the downstream stage consumes if_*.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ready, stall, redirect, halt;
  logic [31:0] redirect_target;
  logic        imem_req, if_valid, squash, halted, fault;
  logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, if_npc;
  logic [1:0]  dbg_state;
  logic        w_req, w_valid, w_squash, w_halted, w_fault;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_npc;
  logic [1:0]  w_state;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetches, perf_stall_cycles, w_pf, w_ps;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem(imem_addr);
  assign w_rdata    = mem(w_addr);

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(clk), .RST(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_target(redirect_target), .halt(halt),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_npc(if_npc),
    .squash(squash), .halted(halted), .fault(fault), .dbg_state(dbg_state)
`ifdef FETCH_PERF_EN
    , .perf_fetches(perf_fetches), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .CLK(clk), .RST(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rdata(w_rdata), .stall(1'b0),
    .redirect(1'b0), .redirect_target(32'h0), .halt(1'b0),
    .if_valid(w_valid), .if_instr(w_instr), .if_pc(w_pc), .if_npc(w_npc),
    .squash(w_squash), .halted(w_halted), .fault(w_fault), .dbg_state(w_state)
`ifdef FETCH_PERF_EN
    , .perf_fetches(w_pf), .perf_stall_cycles(w_ps)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream consumes if_* at every edge where stall=0.
  always @(negedge clk) begin
    if (!rst && if_valid && !stall) begin
      if (exp_q.size() == 0) begin
        check("unexpected_consume", if_pc, 32'hDEAD_BEEF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_if_pc", if_pc, e);
        check("sb_if_instr", if_instr, mem(e));
        check("sb_if_npc", if_npc, e + 32'd4);
      end
    end
  end

  initial begin
    rst = 1'b1; imem_ready = 1'b1; stall = 1'b0; redirect = 1'b0;
    halt = 1'b0; redirect_target = '0;
    tick(); tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_flags", {30'd0, halted, fault}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
    rst = 1'b0;
    check("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr0", imem_addr, 32'h0);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    tick();
    check("first_valid", {31'd0, if_valid}, 32'd1);
    check("first_pc", if_pc, 32'h0);
    check("first_npc", if_npc, 32'h4);
    check("addr_4", imem_addr, 32'h4);
    check("wrap_if_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_if_npc", w_npc, 32'h0);
    check("wrap_addr1", w_addr, 32'h0);
    exp_q.push_back(32'h4);
    tick();
    check("addr_8", imem_addr, 32'h8);
    stall = 1'b1;
    exp_q.push_back(32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("buf_state", {30'd0, dbg_state}, 32'd2);
      check("buf_req", {31'd0, imem_req}, 32'd0);
      check("buf_hold_pc", if_pc, 32'h4);
    end
    stall = 1'b0;
    tick();
    check("drain_pc", if_pc, 32'h8);
    check("drain_addr", imem_addr, 32'hC);
    check("drain_state", {30'd0, dbg_state}, 32'd1);
    exp_q.push_back(32'hC);
    tick();
    redirect = 1'b1; redirect_target = 32'h100;
    #1 check("squash_hi", {31'd0, squash}, 32'd1);
    tick();
    redirect = 1'b0;
    #1 check("squash_lo", {31'd0, squash}, 32'd0);
    check("redir_valid", {31'd0, if_valid}, 32'd0);
    check("redir_addr", imem_addr, 32'h100);
    exp_q.push_back(32'h100);
    tick();
    check("target_pc", if_pc, 32'h100);
    imem_ready = 1'b0;
    tick();
    check("bubble_valid", {31'd0, if_valid}, 32'd0);
    check("bubble_addr", imem_addr, 32'h104);
    imem_ready = 1'b1;
    exp_q.push_back(32'h104);
    tick();
    check("after_bubble_pc", if_pc, 32'h104);
    stall = 1'b1;
    tick();
    check("buf2_state", {30'd0, dbg_state}, 32'd2);
    stall = 1'b0; redirect = 1'b1; redirect_target = 32'h200;
    tick();
    redirect = 1'b0;
    check("buf_redir_valid", {31'd0, if_valid}, 32'd0);
    check("buf_redir_addr", imem_addr, 32'h200);
    check("buf_redir_state", {30'd0, dbg_state}, 32'd1);
    exp_q.push_back(32'h200);
    tick();
    check("pc_200", if_pc, 32'h200);
    halt = 1'b1; redirect = 1'b1; redirect_target = 32'h300;
    #1 check("halt_squash", {31'd0, squash}, 32'd0);
    tick();
    halt = 1'b0; redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("halt_flags", {30'd0, halted, fault}, 32'd2);
      check("halt_req", {31'd0, imem_req}, 32'd0);
      check("halt_addr", imem_addr, 32'h204);
      check("halt_valid", {31'd0, if_valid}, 32'd0);
      tick();
    end
    rst = 1'b1;
    #1 check("async_rst_flags", {30'd0, halted, fault}, 32'd0);
    check("async_rst_addr", imem_addr, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    exp_q.push_back(32'h0);
    tick();
    redirect = 1'b1; redirect_target = 32'h102;
    #1 check("mis_squash", {31'd0, squash}, 32'd1);
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mis_flags", {30'd0, halted, fault}, 32'd3);
      check("mis_req", {31'd0, imem_req}, 32'd0);
      check("mis_addr", imem_addr, 32'h4);
      check("mis_state", {30'd0, dbg_state}, 32'd3);
      tick();
    end
    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
